// File: rtl/hls_macc_pkg.sv
// Shared definitions for the macc result collector: field layout, frame entry
// format and the frame-assembly state encoding.
package hls_macc_pkg;

  localparam int FIELD_W = 32;
  localparam int FRAME_W = 96;
  localparam int A_LSB   = 0;
  localparam int B_LSB   = 32;
  localparam int C_LSB   = 64;
  localparam int ENTRY_W = FRAME_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PART = 1'b1
  } state_e;

  // One buffered result: error flag above the 96-bit payload.
  typedef struct packed {
    logic               err;
    logic [FRAME_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/hls_macc_res_fifo.sv
// First-word-fall-through result FIFO; the head entry is presented whenever
// the FIFO holds at least one entry.
module hls_macc_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic                   accepted,
  output logic                   valid,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             pop_ok;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    accepted = push && ((count_q != LW'(DEPTH)) || pop_ok);
    wr_ptr_d = accepted ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + LW'(accepted) - LW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accepted) mem_q[wr_ptr_q] <= din;
  end

  assign valid = (count_q != '0);
  assign dout  = valid ? mem_q[rd_ptr_q] : '0;
  assign level = count_q;

endmodule

// File: rtl/hls_macc_0_collect.sv
// Collects the three macc result fields into 96-bit frames, zero-filling
// fields still missing at ap_done, and buffers frames for a downstream consumer.
module hls_macc_0_collect
  import hls_macc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_done,
  input  logic [31:0]                 out13,
  input  logic                        out13_ap_vld,
  input  logic [31:0]                 out30_o,
  input  logic                        out30_o_ap_vld,
  input  logic [31:0]                 out31,
  input  logic                        out31_ap_vld,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [95:0]                 m_data,
  output logic                        m_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic [CNT_W-1:0]            txn_count
);

  state_e             state_q, state_d;
  logic [2:0]         flags_q, flags_d;
  logic [FIELD_W-1:0] cap_a_q, cap_a_d;
  logic [FIELD_W-1:0] cap_b_q, cap_b_d;
  logic [FIELD_W-1:0] cap_c_q, cap_c_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   txn_count_q, txn_count_d;

  logic [2:0]         stb;
  logic [2:0]         held;
  logic [2:0]         seen;
  logic               push_evt;
  logic               accepted;
  entry_t             frame;
  entry_t             head;

  assign stb = {out31_ap_vld, out30_o_ap_vld, out13_ap_vld};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (push_evt)  state_d = ST_IDLE;
    else if (|stb) state_d = ST_PART;
  end

  // Fields strobed this cycle count toward completion alongside the held flags.
  always_comb begin
    held     = (state_q == ST_PART) ? flags_q : 3'b000;
    seen     = held | stb;
    push_evt = (&seen) | (ap_done & (|seen));
    frame    = '0;
    frame.err = ~(&seen);
    frame.data[A_LSB +: FIELD_W] = stb[0] ? out13   : (held[0] ? cap_a_q : '0);
    frame.data[B_LSB +: FIELD_W] = stb[1] ? out30_o : (held[1] ? cap_b_q : '0);
    frame.data[C_LSB +: FIELD_W] = stb[2] ? out31   : (held[2] ? cap_c_q : '0);
  end

  always_comb begin
    flags_d     = push_evt ? 3'b000 : seen;
    cap_a_d     = stb[0] ? out13   : cap_a_q;
    cap_b_d     = stb[1] ? out30_o : cap_b_q;
    cap_c_d     = stb[2] ? out31   : cap_c_q;
    txn_count_d = txn_count_q + CNT_W'(accepted);
    overflow_d  = overflow_q;
    // A drop in the same cycle as a clear leaves the flag set.
    if (push_evt && !accepted) overflow_d = 1'b1;
    else if (clr_overflow)     overflow_d = 1'b0;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      flags_q     <= '0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      cap_c_q     <= '0;
      overflow_q  <= 1'b0;
      txn_count_q <= '0;
    end else begin
      flags_q     <= flags_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      cap_c_q     <= cap_c_d;
      overflow_q  <= overflow_d;
      txn_count_q <= txn_count_d;
    end
  end

  hls_macc_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_res_fifo (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .push     (push_evt),
    .pop      (m_ready),
    .din      (frame),
    .accepted (accepted),
    .valid    (m_valid),
    .dout     (head),
    .level    (fifo_level)
  );

  assign m_data    = head.data;
  assign m_err     = head.err;
  assign overflow  = overflow_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_hls_macc_0_collect.sv
// Scoreboard bench for hls_macc_0_collect: directed scenarios plus random
// strobe traffic checked against a frame-level reference model.
module tb_hls_macc_0_collect;

  localparam int D  = 4;
  localparam int CW = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          ap_done = 1'b0;
  logic [31:0]   out13 = '0, out30_o = '0, out31 = '0;
  logic          out13_ap_vld = 1'b0, out30_o_ap_vld = 1'b0, out31_ap_vld = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [95:0]   m_data;
  logic          m_err;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic          clr_overflow = 1'b0;
  logic [CW-1:0] txn_count;

  hls_macc_0_collect #(.FIFO_DEPTH(D), .CNT_W(CW)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .ap_done        (ap_done),
    .out13          (out13),
    .out13_ap_vld   (out13_ap_vld),
    .out30_o        (out30_o),
    .out30_o_ap_vld (out30_o_ap_vld),
    .out31          (out31),
    .out31_ap_vld   (out31_ap_vld),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_err          (m_err),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clr_overflow   (clr_overflow),
    .txn_count      (txn_count)
  );

  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: which fields have arrived, their values, the expected
  // output order, and the externally visible counters.
  bit            have [3];
  logic [31:0]   val  [3];
  logic [96:0]   exp_q [$];
  int            lvl;
  bit            ovf;
  logic [CW-1:0] txn;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      have[i] = 1'b0;
      val[i]  = '0;
    end
    exp_q.delete();
    lvl = 0;
    ovf = 1'b0;
    txn = '0;
  endtask

  // Drive one cycle of inputs, predict its effect, and advance past the edge.
  task automatic drive_cycle(input bit [2:0] stb, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input bit done, input bit rdy, input bit clr);
    logic [31:0] ins [3];
    logic [96:0] f;
    bit          complete, any, pop_m;
    int          n_lvl;
    bit          n_ovf;
    logic [CW-1:0] n_txn;
    out13 = a; out30_o = b; out31 = c;
    out13_ap_vld = stb[0]; out30_o_ap_vld = stb[1]; out31_ap_vld = stb[2];
    ap_done = done; m_ready = rdy; clr_overflow = clr;

    ins[0] = a; ins[1] = b; ins[2] = c;
    for (int i = 0; i < 3; i++)
      if (stb[i]) begin
        have[i] = 1'b1;
        val[i]  = ins[i];
      end
    complete = have[0] && have[1] && have[2];
    any      = have[0] || have[1] || have[2];
    pop_m    = (lvl > 0) && rdy;
    n_lvl    = lvl - (pop_m ? 1 : 0);
    n_txn    = txn;
    n_ovf    = clr ? 1'b0 : ovf;
    if (complete || (done && any)) begin
      f = {!complete,
           have[2] ? val[2] : 32'h0,
           have[1] ? val[1] : 32'h0,
           have[0] ? val[0] : 32'h0};
      if (lvl < D || pop_m) begin
        exp_q.push_back(f);
        n_lvl = n_lvl + 1;
        n_txn = txn + 1'b1;
      end else begin
        n_ovf = 1'b1;
      end
      for (int i = 0; i < 3; i++) have[i] = 1'b0;
    end
    @(posedge ap_clk);
    #1;
    lvl = n_lvl;
    ovf = n_ovf;
    txn = n_txn;
  endtask

  task automatic idle(input bit rdy);
    drive_cycle(3'b000, $urandom, $urandom, $urandom, 1'b0, rdy, 1'b0);
  endtask

  task automatic full_frame(input logic [31:0] tag, input bit rdy);
    drive_cycle(3'b111, tag, tag + 32'h100, tag + 32'h200, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    out13_ap_vld = 1'b0; out30_o_ap_vld = 1'b0; out31_ap_vld = 1'b0;
    ap_done = 1'b0; m_ready = 1'b0; clr_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_err", m_err, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_txn_count", txn_count, 0);
    ap_rst_n = 1'b1;
  endtask

  // Monitor: mid-cycle, compare visible state and any accepted frame.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      check("m_valid", m_valid, (lvl > 0));
      check("fifo_level", fifo_level, lvl);
      check("overflow", overflow, ovf);
      check("txn_count", txn_count, txn);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: got %0h, expected no frame", {m_err, m_data});
        end else begin
          check("frame", {m_err, m_data}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // All three strobes plus ap_done in one cycle.
    drive_cycle(3'b111, 32'd5, 32'd7, 32'd9, 1'b1, 1'b0, 1'b0);
    check("d1_valid", m_valid, 1);
    check("d1_data", m_data, 96'h00000009_00000007_00000005);
    check("d1_err", m_err, 0);
    check("d1_txn", txn_count, 1);
    idle(1'b1);

    // Fields spread over several cycles: A, then C, then B.
    drive_cycle(3'b001, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    drive_cycle(3'b100, 32'd0, 32'd0, 32'd3, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("d2_no_early_push", m_valid, 0);
    drive_cycle(3'b010, 32'd0, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
    check("d2_valid", m_valid, 1);
    check("d2_data", m_data, {32'd3, 32'd2, 32'd1});
    check("d2_err", m_err, 0);
    idle(1'b1);

    // Partial frame closed by ap_done, then ap_done with nothing pending.
    drive_cycle(3'b001, 32'hAA, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive_cycle(3'b000, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("d3_data", m_data, {32'h0, 32'h0, 32'hAA});
    check("d3_err", m_err, 1);
    idle(1'b1);
    drive_cycle(3'b000, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("d3_empty_done", fifo_level, 0);

    // Six complete frames into a depth-4 FIFO with no consumer.
    do_reset();
    for (int i = 1; i <= 6; i++) full_frame(32'(i), 1'b0);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_txn", txn_count, 4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    drive_cycle(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared", overflow, 0);

    // Full FIFO: push with simultaneous pop is accepted; drop beats clear.
    for (int i = 0; i < 4; i++) full_frame(32'h10 + 32'(i), 1'b0);
    full_frame(32'h20, 1'b1);
    check("full_pop_level", fifo_level, 4);
    check("full_pop_ovf", overflow, 0);
    drive_cycle(3'b111, 32'h30, 32'h31, 32'h32, 1'b0, 1'b0, 1'b1);
    check("set_beats_clr", overflow, 1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Reset with two frames buffered and a partial frame pending.
    full_frame(32'h40, 1'b0);
    full_frame(32'h50, 1'b0);
    drive_cycle(3'b001, 32'hDEAD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive_cycle(3'b110, 32'd0, 32'h61, 32'h62, 1'b0, 1'b0, 1'b0);
    check("post_rst_no_stale", m_valid, 0);
    drive_cycle(3'b001, 32'h60, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("post_rst_first", m_data, {32'h62, 32'h61, 32'h60});
    idle(1'b1);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      bit [2:0] s;
      s[0] = ($urandom_range(0, 2) == 0);
      s[1] = ($urandom_range(0, 2) == 0);
      s[2] = ($urandom_range(0, 2) == 0);
      drive_cycle(s, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 15) == 0));
    end

    // Drain within a bounded number of cycles.
    for (int n = 0; n < 20 && lvl > 0; n++) idle(1'b1);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_m_valid", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
